l2_spandex_out_arbiter: RTL and testbench



---
 rtl/l2_spandex_out_arbiter.sv | 151 +++++++++++++++
 tb/tb_l2_spandex_out_arbiter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/l2_spandex_out_arbiter.sv
// Outbound message arbiter for the L2 Spandex cache: NCH buffered valid/ready channels serialised onto one registered, channel-tagged output.
// Define SPANDEX_OUT_FIXED_PRIO_EN for strict lowest-index-first priority; otherwise round-robin.
module l2_spandex_out_arbiter #(
   parameter int NCH   = 3,
   parameter int MSG_W = 64,
   parameter int DEPTH = 4,
   localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NCH-1:0]         in_valid,
   output logic [NCH-1:0]         in_ready,
   input  logic [NCH*MSG_W-1:0]   in_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [MSG_W-1:0]       out_data,
   output logic [CH_W-1:0]        out_chan,
   output logic                   idle
);

   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [MSG_W-1:0]            r_mem [NCH][DEPTH];
   logic [NCH-1:0][PTR_W-1:0]   r_wrPtr;
   logic [NCH-1:0][PTR_W-1:0]   r_rdPtr;
   logic [NCH-1:0][CNT_W-1:0]   r_count;
   logic                        r_outValid;
   logic [MSG_W-1:0]            r_outData;
   logic [CH_W-1:0]             r_outChan;

   logic [NCH-1:0]              w_notEmpty;
   logic [NCH-1:0]              w_push;
   logic [NCH-1:0]              w_pop;
   logic                        w_load;
   logic                        w_grantValid;
   logic [CH_W-1:0]             w_grant;
   logic [MSG_W-1:0]            w_head;

   // Ready depends only on registered occupancy, so a same-cycle pop never frees a slot early.
   always_comb begin
      for (int i = 0; i < NCH; i++) begin
         w_notEmpty[i] = (r_count[i] != '0);
         in_ready[i]   = !rst && (r_count[i] < FULL_CNT);
         w_push[i]     = in_valid[i] && in_ready[i];
      end
   end

   assign w_load = !r_outValid || out_ready;

`ifdef SPANDEX_OUT_FIXED_PRIO_EN
   always_comb begin
      w_grantValid = 1'b0;
      w_grant      = '0;
      for (int i = NCH - 1; i >= 0; i--) begin
         if (w_notEmpty[i]) begin
            w_grantValid = 1'b1;
            w_grant      = CH_W'(i);
         end
      end
   end
`else
   logic [CH_W-1:0] r_rr;

   // Winner is the non-empty channel at the smallest circular distance from r_rr.
   always_comb begin
      int off;
      int bestOff;
      w_grantValid = 1'b0;
      w_grant      = '0;
      off          = 0;
      bestOff      = NCH;
      for (int i = 0; i < NCH; i++) begin
         if (w_notEmpty[i]) begin
            off = (i + NCH - int'(r_rr)) % NCH;
            if (off < bestOff) begin
               bestOff      = off;
               w_grantValid = 1'b1;
               w_grant      = CH_W'(i);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rr <= '0;
      end else if (w_load && w_grantValid) begin
         r_rr <= CH_W'((int'(w_grant) + 1) % NCH);
      end
   end
`endif

   always_comb begin
      for (int i = 0; i < NCH; i++) begin
         w_pop[i] = w_load && w_grantValid && (w_grant == CH_W'(i));
      end
   end

   assign w_head = r_mem[w_grant][r_rdPtr[w_grant]];

   always_ff @(posedge clk) begin
      for (int i = 0; i < NCH; i++) begin
         if (w_push[i]) begin
            r_mem[i][r_wrPtr[i]] <= in_data[i*MSG_W +: MSG_W];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wrPtr    <= '0;
         r_rdPtr    <= '0;
         r_count    <= '0;
         r_outValid <= 1'b0;
         r_outData  <= '0;
         r_outChan  <= '0;
      end else begin
         for (int i = 0; i < NCH; i++) begin
            if (w_push[i]) begin
               r_wrPtr[i] <= r_wrPtr[i] + PTR_W'(1);
            end
            if (w_pop[i]) begin
               r_rdPtr[i] <= r_rdPtr[i] + PTR_W'(1);
            end
            case ({w_push[i], w_pop[i]})
               2'b10:   r_count[i] <= r_count[i] + CNT_W'(1);
               2'b01:   r_count[i] <= r_count[i] - CNT_W'(1);
               default: r_count[i] <= r_count[i];
            endcase
         end
         // While stalled the output register and every FIFO head are frozen.
         if (w_load) begin
            if (w_grantValid) begin
               r_outValid <= 1'b1;
               r_outData  <= w_head;
               r_outChan  <= w_grant;
            end else begin
               r_outValid <= 1'b0;
            end
         end
      end
   end

   assign out_valid = r_outValid;
   assign out_data  = r_outData;
   assign out_chan  = r_outChan;
   assign idle      = (w_notEmpty == '0) && !r_outValid;

endmodule

// File: tb/tb_l2_spandex_out_arbiter.sv
// Self-checking bench for l2_spandex_out_arbiter: directed plan steps plus random traffic against a queue-based model.
module tb_l2_spandex_out_arbiter;

   localparam int NCH   = 3;
   localparam int MSG_W = 16;
   localparam int DEPTH = 4;
   localparam int CH_W  = 2;

   logic                   clk;
   logic                   rst;
   logic [NCH-1:0]         inValid;
   logic [NCH-1:0]         inReady;
   logic [NCH*MSG_W-1:0]   inData;
   logic                   outValid;
   logic                   outReady;
   logic [MSG_W-1:0]       outData;
   logic [CH_W-1:0]        outChan;
   logic                   idle;

   l2_spandex_out_arbiter #(.NCH(NCH), .MSG_W(MSG_W), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (inValid),
      .in_ready  (inReady),
      .in_data   (inData),
      .out_valid (outValid),
      .out_ready (outReady),
      .out_data  (outData),
      .out_chan  (outChan),
      .idle      (idle)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int checks = 0;
   int errors = 0;

   // Reference model: one queue per channel plus the output register and rotation pointer.
   logic [MSG_W-1:0] mq [NCH][$];
   int               mRr = 0;
   logic             mValid = 1'b0;
   logic [MSG_W-1:0] mData = '0;
   int               mChan = 0;
   bit               modelKnown = 1'b0;

   int               obsChan [$];
   logic [MSG_W-1:0] obsData [$];

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   function automatic int pickGrant();
`ifdef SPANDEX_OUT_FIXED_PRIO_EN
      for (int i = 0; i < NCH; i++) if (mq[i].size() > 0) return i;
`else
      for (int k = 0; k < NCH; k++) if (mq[(mRr + k) % NCH].size() > 0) return (mRr + k) % NCH;
`endif
      return -1;
   endfunction

   // One clock cycle: drive inputs, compare against the model, then advance the model across the edge.
   task automatic applyStimulus(input logic [NCH-1:0] v, input logic [NCH*MSG_W-1:0] d,
                                input logic ordy, input logic r);
      bit accept [NCH];
      bit allEmpty;
      int g;
      inValid  = v;
      inData   = d;
      outReady = ordy;
      rst      = r;
      #1;
      for (int i = 0; i < NCH; i++) begin
         accept[i] = !r && (mq[i].size() < DEPTH);
         if (modelKnown || r)
            checkOutput($sformatf("in_ready[%0d]", i), 32'(inReady[i]), 32'(accept[i]));
      end
      if (modelKnown) begin
         allEmpty = 1'b1;
         for (int i = 0; i < NCH; i++) if (mq[i].size() > 0) allEmpty = 1'b0;
         checkOutput("out_valid", 32'(outValid), 32'(mValid));
         checkOutput("out_data", 32'(outData), 32'(mData));
         checkOutput("out_chan", 32'(outChan), 32'(mChan));
         checkOutput("idle", 32'(idle), 32'(allEmpty && !mValid));
         if (mValid && ordy && !r) begin
            obsChan.push_back(int'(outChan));
            obsData.push_back(outData);
         end
      end
      if (r) begin
         for (int i = 0; i < NCH; i++) mq[i].delete();
         mRr = 0; mValid = 1'b0; mData = '0; mChan = 0;
         modelKnown = 1'b1;
      end else begin
         if (!mValid || ordy) begin
            g = pickGrant();
            if (g >= 0) begin
               mData  = mq[g].pop_front();
               mChan  = g;
               mValid = 1'b1;
               mRr    = (g + 1) % NCH;
            end else begin
               mValid = 1'b0;
            end
         end
         for (int i = 0; i < NCH; i++)
            if (v[i] && accept[i]) mq[i].push_back(d[i*MSG_W +: MSG_W]);
      end
      @(posedge clk);
      #1;
   endtask

   function automatic logic [NCH*MSG_W-1:0] pack3(input logic [MSG_W-1:0] d0, d1, d2);
      return {d2, d1, d0};
   endfunction

   int expSeq [6];
   logic [NCH*MSG_W-1:0] rndData;

   initial begin
      inValid = '0; inData = '0; outReady = 1'b0; rst = 1'b1;
      applyStimulus('0, '0, 1'b0, 1'b1);
      applyStimulus('0, '0, 1'b0, 1'b1);
      applyStimulus('0, '0, 1'b0, 1'b0);

      // Fill ch0 while stalled: five accepted (one in output register), the sixth ignored.
      for (int k = 0; k < 6; k++)
         applyStimulus(3'b001, pack3(16'h0100 + 16'(k), 16'h0, 16'h0), 1'b0, 1'b0);
      checkOutput("fill_held_data", 32'(outData), 32'h0100);
      checkOutput("fill_in_ready0", 32'(inReady[0]), 32'h0);

      // Reset with messages buffered and out_valid high, out_ready high during reset.
      applyStimulus('0, '0, 1'b1, 1'b1);
      checkOutput("rst_out_valid", 32'(outValid), 32'h0);
      checkOutput("rst_idle", 32'(idle), 32'h1);
      obsData.delete(); obsChan.delete();
      for (int k = 0; k < 4; k++) applyStimulus('0, '0, 1'b1, 1'b0);
      checkOutput("rst_no_stale", 32'(obsData.size()), 32'h0);

      // Single push on ch1.
      applyStimulus(3'b010, pack3(16'h0, 16'hBEEF, 16'h0), 1'b0, 1'b0);
      applyStimulus('0, '0, 1'b0, 1'b0);
      checkOutput("beef_data", 32'(outData), 32'hBEEF);
      checkOutput("beef_chan", 32'(outChan), 32'h1);
      checkOutput("beef_idle", 32'(idle), 32'h0);
      applyStimulus('0, '0, 1'b1, 1'b0);
      applyStimulus('0, '0, 1'b1, 1'b0);

      // Two messages per channel, then drain.
      applyStimulus('0, '0, 1'b0, 1'b1);
      applyStimulus(3'b111, pack3(16'hA000, 16'hA100, 16'hA200), 1'b0, 1'b0);
      applyStimulus(3'b111, pack3(16'hA001, 16'hA101, 16'hA201), 1'b0, 1'b0);
      obsData.delete(); obsChan.delete();
      for (int k = 0; k < 8; k++) applyStimulus('0, '0, 1'b1, 1'b0);
`ifdef SPANDEX_OUT_FIXED_PRIO_EN
      expSeq = '{0, 0, 1, 1, 2, 2};
`else
      expSeq = '{0, 1, 2, 0, 1, 2};
`endif
      checkOutput("arb_count", 32'(obsChan.size()), 32'd6);
      for (int k = 0; k < 6 && k < obsChan.size(); k++)
         checkOutput($sformatf("arb_chan[%0d]", k), 32'(obsChan[k]), 32'(expSeq[k]));

      // Full-rate streaming on ch2 wraps the pointers.
      obsData.delete(); obsChan.delete();
      for (int k = 1; k <= 10; k++)
         applyStimulus(3'b100, pack3(16'h0, 16'h0, 16'(k)), 1'b1, 1'b0);
      applyStimulus('0, '0, 1'b1, 1'b0);
      applyStimulus('0, '0, 1'b1, 1'b0);
      checkOutput("wrap_count", 32'(obsData.size()), 32'd10);
      for (int k = 0; k < 10 && k < obsData.size(); k++)
         checkOutput($sformatf("wrap_data[%0d]", k), 32'(obsData[k]), 32'(k + 1));

      // Random traffic with occasional reset.
      for (int k = 0; k < 400; k++) begin
         for (int i = 0; i < NCH; i++) rndData[i*MSG_W +: MSG_W] = 16'($urandom);
         applyStimulus(3'($urandom_range(0, 7)), rndData,
                       1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 99) == 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
